// File: rtl/alu_mul_sequencer.sv
// ============================================================================
// Module   : alu_mul_sequencer
// Brief    : Shift-add 64x64 multiplier controller (low 64 product bits)
//            that performs its additions through the shared execute ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mul_sequencer (
    input  logic        input_clk,
    input  logic        input_reset_n,
    input  logic        input_start,
    input  logic [63:0] input_multiplicand,
    input  logic [63:0] input_multiplier,
    output logic        output_busy,
    output logic        output_done,
    output logic [63:0] output_product,
    output logic [63:0] output_alu_data_1,
    output logic [63:0] output_alu_data_2,
    output logic [3:0]  output_alu_opcode,
    input  logic [63:0] input_alu_result
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;
    localparam logic [3:0] c_op_add  = 4'b0010;

    logic [1:0]  r_state;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [63:0] r_mplier;

    logic        w_in_run;

    assign w_in_run = (r_state == c_st_run);

    // ALU drive depends only on registered state, never on input_start.
    always_comb begin
        output_alu_opcode = c_op_add;
        output_alu_data_1 = 64'd0;
        output_alu_data_2 = 64'd0;
        if (w_in_run) begin
            output_alu_data_1 = r_acc;
            output_alu_data_2 = r_mplier[0] ? r_mcand : 64'd0;
        end
    end

    assign output_busy    = (r_state == c_st_run) || (r_state == c_st_done);
    assign output_done    = (r_state == c_st_done);
    assign output_product = r_acc;

    always_ff @(posedge input_clk or negedge input_reset_n) begin
        if (!input_reset_n) begin
            r_state  <= c_st_idle;
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 64'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (input_start) begin
                        r_mcand  <= input_multiplicand;
                        r_mplier <= input_multiplier;
                        r_acc    <= 64'd0;
                        r_state  <= (input_multiplier == 64'd0) ? c_st_done : c_st_run;
                    end
                end
                c_st_run: begin
                    r_acc    <= input_alu_result;
                    r_mcand  <= {r_mcand[62:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[63:1]};
                    // Finish once no set multiplier bits remain above bit 0.
                    if (r_mplier[63:1] == 63'd0) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Brief    : Scoreboard bench for alu_mul_sequencer with a behavioural ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mul_sequencer;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] mcand;
    logic [63:0] mplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [63:0] alu_d1;
    logic [63:0] alu_d2;
    logic [3:0]  alu_op;
    logic [63:0] alu_res;

    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    alu_mul_sequencer dut (
        .input_clk          (clk),
        .input_reset_n      (rst_n),
        .input_start        (start),
        .input_multiplicand (mcand),
        .input_multiplier   (mplier),
        .output_busy        (busy),
        .output_done        (done),
        .output_product     (product),
        .output_alu_data_1  (alu_d1),
        .output_alu_data_2  (alu_d2),
        .output_alu_opcode  (alu_op),
        .input_alu_result   (alu_res)
    );

    // Shared ALU stand-in: only the add opcode is exercised here.
    assign alu_res = (alu_op == 4'b0010) ? (alu_d1 + alu_d2) : 64'hBAD0_BAD0_BAD0_BAD0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("product", product, e.prod);
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_prod, input int n);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        e.prod = exp_prod;
        e.cyc  = cyc + n + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        mcand  = 64'h5555_AAAA_5555_AAAA;
        mplier = 64'hAAAA_5555_AAAA_5555;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout: got busy=%0b pending=%0d expected idle", busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        mcand  = 64'd0;
        mplier = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_opcode", 64'(alu_op), 64'd2);
        check("rst_d1", alu_d1, 64'd0);
        check("rst_d2", alu_d2, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3 x 5: RUN cycles 1..3, done in cycle 4
        issue(64'd3, 64'd5, 64'd15, 3);
        check("c1_busy", 64'(busy), 64'd1);
        check("c1_op", 64'(alu_op), 64'd2);
        check("c1_d1", alu_d1, 64'd0);
        check("c1_d2", alu_d2, 64'd3);
        @(negedge clk);
        check("c2_d1", alu_d1, 64'd3);
        check("c2_d2", alu_d2, 64'd0);
        @(negedge clk);
        check("c3_d1", alu_d1, 64'd3);
        check("c3_d2", alu_d2, 64'd12);
        check("c3_done", 64'(done), 64'd0);
        @(negedge clk);
        check("c4_busy", 64'(busy), 64'd1);
        check("c4_done", 64'(done), 64'd1);
        check("c4_d2", alu_d2, 64'd0);
        @(negedge clk);
        check("c5_busy", 64'(busy), 64'd0);
        check("c5_done", 64'(done), 64'd0);
        check("c5_hold", product, 64'd15);

        // Zero multiplier: DONE straight away, no add cycle
        issue(64'hDEAD, 64'd0, 64'd0, 0);
        check("z_done", 64'(done), 64'd1);
        check("z_busy", 64'(busy), 64'd1);
        check("z_d2", alu_d2, 64'd0);
        wait_done();

        issue(64'h1234_5678, 64'd9, 64'hA3D7_0A38, 4);
        wait_done();
        issue(64'h8000_0000_0000_0001, 64'd3, 64'h8000_0000_0000_0003, 2);
        wait_done();
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64);
        wait_done();
        issue(64'd7, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64);
        wait_done();
        check("top_hold", product, 64'h8000_0000_0000_0000);

        // Start with new operands during RUN must be ignored
        issue(64'd3, 64'd5, 64'd15, 3);
        start  = 1'b1;
        mcand  = 64'd9;
        mplier = 64'd9;
        check("ign_busy1", 64'(busy), 64'd1);
        @(negedge clk);
        check("ign_busy2", 64'(busy), 64'd1);
        @(negedge clk);
        check("ign_busy3", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);
        check("ign_product", product, 64'd15);

        // Asynchronous reset in RUN cycle 2
        issue(64'd3, 64'd5, 64'd15, 3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_done", 64'(done), 64'd0);
        check("mr_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(64'd2, 64'd2, 64'd4, 2);
        wait_done();
        check("post_rst_product", product, 64'd4);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
